// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the CPU core and an 8-bit
// RAM/IO bus. Instruction fetch (IF, 4-byte reads) and load/store (LS,
// 1/2/4-byte reads or writes) share the bus under round-robin arbitration.
// Each access is split into little-endian byte transfers at addr+k.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (0 = bus lent to debug, freeze)
//   if_req_in/if_addr_in -> if_done_out (1-cycle pulse), if_data_out
//   ls_req_in/ls_wr_in/ls_size_in/ls_addr_in/ls_wdata_in
//                        -> ls_done_out (1-cycle pulse), ls_rdata_out
//   mem_din (read byte for the address driven in the current cycle),
//   mem_dout, mem_a, mem_wr (write strobe, gated by rdy_in)
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_wr_in,
  input  logic [1:0]            ls_size_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_ls;   // last grant went to LS
  logic                  r_sel_ls;    // current transfer belongs to LS
  logic                  r_resume;    // a stall hit READ; next live edge only re-issues
  logic [1:0]            r_k;         // index of the byte on the bus
  logic [1:0]            r_last_idx;  // index of the final byte (n-1)
  logic [31:0]           r_wdata;     // store data, shifted down as bytes go out
  logic [31:0]           r_buf;       // read assembly buffer
  logic [31:0]           r_if_data;
  logic [31:0]           r_ls_data;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_if_done;
  logic                  r_ls_done;

  logic                  w_grant_if;
  logic                  w_grant_ls;
  logic                  w_last_byte;
  logic [1:0]            w_ls_last_idx;
  logic [31:0]           w_buf_next;

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    if (if_req_in && ls_req_in) begin
      if (r_last_ls) begin
        w_grant_if = 1'b1;
      end else begin
        w_grant_ls = 1'b1;
      end
    end else if (if_req_in) begin
      w_grant_if = 1'b1;
    end else if (ls_req_in) begin
      w_grant_ls = 1'b1;
    end else begin
      w_grant_if = 1'b0;
      w_grant_ls = 1'b0;
    end
  end

  // Byte bookkeeping: last-byte detect, LS size decode, read assembly.
  always_comb begin
    w_last_byte = (r_k == r_last_idx);
    w_buf_next  = r_buf | ({24'd0, mem_din} << {r_k, 3'b000});
    case (ls_size_in)
      2'b00:   w_ls_last_idx = 2'd0;
      2'b01:   w_ls_last_idx = 2'd1;
      default: w_ls_last_idx = 2'd3;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_if) begin
          w_next_state = ST_READ;
        end else if (w_grant_ls) begin
          w_next_state = ls_wr_in ? ST_WRITE : ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!r_resume && w_last_byte) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_WRITE: begin
        if (w_last_byte) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; frozen while the bus is lent out.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next_state;
    end else begin
      r_state <= r_state;
    end
  end

  // Datapath: grant latching, byte sequencing, capture and completion.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_last_ls  <= 1'b0;
      r_sel_ls   <= 1'b0;
      r_resume   <= 1'b0;
      r_k        <= 2'd0;
      r_last_idx <= 2'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_if_data  <= 32'd0;
      r_ls_data  <= 32'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_if || w_grant_ls) begin
            r_sel_ls  <= w_grant_ls;
            r_last_ls <= w_grant_ls;
            r_k       <= 2'd0;
            r_resume  <= 1'b0;
            r_buf     <= 32'd0;
            if (w_grant_ls) begin
              r_mem_a    <= ls_addr_in;
              r_wdata    <= ls_wdata_in;
              r_mem_dout <= ls_wdata_in[7:0];
              r_mem_wr   <= ls_wr_in;
              r_last_idx <= w_ls_last_idx;
            end else begin
              r_mem_a    <= if_addr_in;
              r_mem_wr   <= 1'b0;
              r_last_idx <= 2'd3;
            end
          end
        end
        ST_READ: begin
          // After a stall the byte in flight is dropped: this edge only
          // re-presents the address, the capture happens one edge later.
          if (r_resume) begin
            r_resume <= 1'b0;
          end else begin
            r_buf <= w_buf_next;
            if (w_last_byte) begin
              if (r_sel_ls) begin
                r_ls_done <= 1'b1;
                r_ls_data <= w_buf_next;
              end else begin
                r_if_done <= 1'b1;
                r_if_data <= w_buf_next;
              end
            end else begin
              r_k     <= r_k + 2'd1;
              r_mem_a <= r_mem_a + A_ONE;
            end
          end
        end
        ST_WRITE: begin
          if (w_last_byte) begin
            r_mem_wr  <= 1'b0;
            r_ls_done <= 1'b1;
          end else begin
            r_k        <= r_k + 2'd1;
            r_mem_a    <= r_mem_a + A_ONE;
            r_wdata    <= {8'd0, r_wdata[31:8]};
            r_mem_dout <= r_wdata[15:8];
          end
        end
        ST_DONE: begin
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
        end
        default: begin
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
        end
      endcase
    end else begin
      if (r_state == ST_READ) begin
        r_resume <= 1'b1;
      end
    end
  end

  assign if_done_out  = r_if_done;
  assign if_data_out  = r_if_data;
  assign ls_done_out  = r_ls_done;
  assign ls_rdata_out = r_ls_data;
  assign mem_a        = r_mem_a;
  assign mem_dout     = r_mem_dout;
  // The debug host owns the bus while rdy_in is low: never write then.
  assign mem_wr       = r_mem_wr & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// request traffic checked against a transaction-level reference model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [1:0]  ls_size_in;
  logic [31:0] ls_addr_in;
  logic [31:0] ls_wdata_in;
  logic        ls_done_out;
  logic [31:0] ls_rdata_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .ls_req_in(ls_req_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
    .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
    .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // Reference memory contents (sparse); unwritten bytes follow a fixed pattern.
  logic [7:0]  ram [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          both_cnt = 0;
  bit          model_last_ls = 1'b0;
  bit          pend_if = 1'b0;
  bit          pend_ls = 1'b0;
  logic [31:0] t_if_addr;
  logic        t_ls_wr;
  logic [1:0]  t_ls_size;
  logic [31:0] t_ls_addr;
  logic [31:0] t_ls_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_1000;
    return base + 32'($urandom_range(0, 31));
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge and the
  // RAM answers for the address now on the bus.
  task automatic tick();
    @(posedge clk_in);
    #1;
    mem_din = ram_rd(mem_a);
    if (if_done_out && ls_done_out) both_cnt++;
  endtask

  task automatic req_if(input logic [31:0] a);
    pend_if = 1'b1; t_if_addr = a;
    if_addr_in = a; if_req_in = 1'b1;
  endtask

  task automatic req_ls(input logic wr, input logic [1:0] size, input logic [31:0] a,
                        input logic [31:0] wd);
    pend_ls = 1'b1; t_ls_wr = wr; t_ls_size = size; t_ls_addr = a; t_ls_wdata = wd;
    ls_wr_in = wr; ls_size_in = size; ls_addr_in = a; ls_wdata_in = wd; ls_req_in = 1'b1;
  endtask

  // Arbitrate among pending requests the way the controller should, then
  // follow the granted transfer cycle by cycle until its done pulse.
  // Called in an IDLE cycle; returns in the following IDLE cycle.
  task automatic serve();
    bit          sel_ls;
    bit          wr;
    bit          done_s;
    int          n;
    int          lat;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic [31:0] obs_data;
    if (pend_if && pend_ls) sel_ls = !model_last_ls;
    else sel_ls = pend_ls;
    model_last_ls = sel_ls;
    if (sel_ls) begin
      a = t_ls_addr; wr = t_ls_wr; n = nbytes(t_ls_size); wd = t_ls_wdata;
    end else begin
      a = t_if_addr; wr = 1'b0; n = 4; wd = 32'd0;
    end
    exp_data = 32'd0;
    for (int k = 0; k < n; k++) exp_data[8*k +: 8] = ram_rd(a + 32'(k));
    lat = 0;
    done_s = 1'b0;
    while (!done_s && lat < 40) begin
      tick();
      lat++;
      // Inputs change after the grant edge; the latched request must win.
      if (lat == 1) begin
        if (sel_ls) begin
          ls_addr_in = $urandom; ls_wdata_in = $urandom;
          ls_size_in = 2'($urandom_range(0, 3)); ls_wr_in = 1'($urandom_range(0, 1));
        end else begin
          if_addr_in = $urandom;
        end
      end
      if (lat <= n) begin
        check_eq("bus_addr", mem_a, a + 32'(lat - 1));
        check_eq("bus_wr", 32'(mem_wr), 32'(wr));
        if (wr) check_eq("bus_dout", 32'(mem_dout), 32'(wd[8*(lat-1) +: 8]));
      end
      done_s = sel_ls ? ls_done_out : if_done_out;
    end
    check_eq(sel_ls ? "ls_latency" : "if_latency", 32'(lat), 32'(n + 1));
    if (wr) begin
      check_eq("wr_after_last", 32'(mem_wr), 32'd0);
      for (int k = 0; k < n; k++) ram[a + 32'(k)] = wd[8*k +: 8];
    end else begin
      obs_data = sel_ls ? ls_rdata_out : if_data_out;
      check_eq(sel_ls ? "ls_rdata" : "if_data", obs_data, exp_data);
    end
    if (sel_ls) begin ls_req_in = 1'b0; pend_ls = 1'b0; end
    else begin if_req_in = 1'b0; pend_if = 1'b0; end
    tick();
    check_eq("done_clear", 32'({if_done_out, ls_done_out}), 32'd0);
  endtask

  initial begin : main
    int          lat;
    int          dcnt;
    logic [31:0] exp_data;
    logic [31:0] wd;
    rst_in = 1'b0; rdy_in = 1'b1; if_req_in = 1'b0; if_addr_in = 32'd0;
    ls_req_in = 1'b0; ls_wr_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = 32'd0;
    ls_wdata_in = 32'd0; mem_din = 8'd0;
    tick(); tick();
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_done", 32'({if_done_out, ls_done_out}), 32'd0);
    check_eq("rst_if_data", if_data_out, 32'd0);
    check_eq("rst_ls_data", ls_rdata_out, 32'd0);
    rst_in = 1'b1;

    // Fetch of a known instruction word.
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    req_if(32'h100); serve();
    check_eq("fetch_word", if_data_out, 32'h0000_0513);

    // Half store crossing a 64 KiB boundary, then read one byte back.
    req_ls(1'b1, 2'b01, 32'h0001_FFFF, 32'h0000_BEEF); serve();
    req_ls(1'b0, 2'b00, 32'h0001_FFFF, 32'd0); serve();
    check_eq("load_byte", ls_rdata_out, 32'h0000_00EF);

    // Reset in the middle of a fetch: everything clears, no done pulse.
    if_addr_in = 32'h100; if_req_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0; if_req_in = 1'b0;
    tick(); tick();
    check_eq("midrst_mem_a", mem_a, 32'd0);
    check_eq("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("midrst_if_data", if_data_out, 32'd0);
    check_eq("midrst_ls_data", ls_rdata_out, 32'd0);
    rst_in = 1'b1;
    model_last_ls = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_done_out || ls_done_out) dcnt++;
    end
    check_eq("midrst_no_done", 32'(dcnt), 32'd0);

    // Tie right after reset goes to LS; IF next; LS re-requests -> IF's tie wins.
    req_if(32'h200);
    req_ls(1'b0, 2'b10, 32'h300, 32'd0);
    serve();
    req_ls(1'b0, 2'b00, 32'h301, 32'd0);
    serve();
    serve();

    // Word load at 0x40 stalled for 3 cycles while byte 1 is on the bus.
    ls_wr_in = 1'b0; ls_size_in = 2'b10; ls_addr_in = 32'h40; ls_req_in = 1'b1;
    model_last_ls = 1'b1;
    exp_data = {ram_rd(32'h43), ram_rd(32'h42), ram_rd(32'h41), ram_rd(32'h40)};
    tick();
    check_eq("stall_a0", mem_a, 32'h40);
    tick();
    check_eq("stall_a1", mem_a, 32'h41);
    rdy_in = 1'b0; mem_din = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_din = 8'hEE;
    end
    rdy_in = 1'b1; mem_din = ram_rd(mem_a);
    check_eq("stall_reissue", mem_a, 32'h41);
    lat = 5;
    while (!ls_done_out && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("stall_latency", 32'(lat), 32'd9);
    check_eq("stall_rdata", ls_rdata_out, exp_data);
    // Done held through a stall in the DONE cycle.
    rdy_in = 1'b0; ls_req_in = 1'b0;
    tick();
    check_eq("done_hold1", 32'(ls_done_out), 32'd1);
    tick();
    check_eq("done_hold2", 32'(ls_done_out), 32'd1);
    rdy_in = 1'b1;
    tick();
    check_eq("done_release", 32'(ls_done_out), 32'd0);

    // Word store at 0x80 with a one-cycle stall on byte 1.
    wd = $urandom;
    ls_wr_in = 1'b1; ls_size_in = 2'b10; ls_addr_in = 32'h80; ls_wdata_in = wd; ls_req_in = 1'b1;
    tick();
    check_eq("wst_a0", mem_a, 32'h80);
    tick();
    check_eq("wst_a1", mem_a, 32'h81);
    check_eq("wst_d1", 32'(mem_dout), 32'(wd[15:8]));
    rdy_in = 1'b0;
    tick();
    check_eq("wst_stall_wr", 32'(mem_wr), 32'd0);
    check_eq("wst_stall_a", mem_a, 32'h81);
    rdy_in = 1'b1;
    tick();
    check_eq("wst_a2", mem_a, 32'h82);
    check_eq("wst_d2", 32'(mem_dout), 32'(wd[23:16]));
    lat = 4;
    while (!ls_done_out && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("wst_latency", 32'(lat), 32'd6);
    for (int k = 0; k < 4; k++) ram[32'h80 + 32'(k)] = wd[8*k +: 8];
    ls_req_in = 1'b0;
    tick();

    // Address wrap.
    req_ls(1'b0, 2'b11, 32'hFFFF_FFFE, 32'd0); serve();

    // Randomized traffic, including back-to-back re-requests and ties.
    for (int it = 0; it < 60; it++) begin
      if (!pend_if && $urandom_range(0, 1) == 1) req_if(rand_addr());
      if (!pend_ls && $urandom_range(0, 1) == 1)
        req_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
      if (!pend_if && !pend_ls) req_if(rand_addr());
      serve();
    end
    while (pend_if || pend_ls) serve();

    check_eq("both_done_cycles", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
